// File: rtl/counter_param.sv
`default_nettype none
// ============================================================================
//  Module      : counter_param
//  Description : Parametrised synchronous up/down counter with modulo limit,
//                wrap/saturate mode, terminal-count pulse and event counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_param #(
    parameter int              WIDTH    = 16,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              SATURATE = 0,
    parameter int              EVT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] num,
    output logic             tc,
    output logic [EVT_W-1:0] evt_cnt
);

    localparam logic [WIDTH-1:0] c_max_val = WIDTH'(MAX_VAL);
    localparam logic [EVT_W-1:0] c_evt_max = '1;

    generate
        if ((WIDTH < 2) || (WIDTH > 32) || (MAX_VAL < 64'd1) ||
            (MAX_VAL > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_params
            $error("counter_param: MAX_VAL must lie in 1..2**WIDTH-1 and WIDTH in 2..32");
        end
    endgenerate

    logic [WIDTH-1:0] r_num;
    logic             r_tc;
    logic [EVT_W-1:0] r_evt;

    logic [WIDTH-1:0] w_num_next;
    logic             w_tc_next;
    logic [EVT_W-1:0] w_evt_next;
    logic             w_at_limit;

    always_comb begin
        w_num_next = r_num;
        w_tc_next  = 1'b0;
        w_evt_next = r_evt;
        w_at_limit = up_dn ? (r_num == c_max_val) : (r_num == '0);

        if (clear) begin
            w_num_next = '0;
            w_evt_next = '0;
        end else if (load) begin
            w_num_next = (load_val > c_max_val) ? c_max_val : load_val;
        end else if (en) begin
            if (w_at_limit) begin
                // Every enabled cycle at a limit is an event, even when holding.
                w_tc_next = 1'b1;
                if (r_evt != c_evt_max) begin
                    w_evt_next = r_evt + 1'b1;
                end
                if (SATURATE == 0) begin
                    w_num_next = up_dn ? '0 : c_max_val;
                end
            end else begin
                w_num_next = up_dn ? (r_num + 1'b1) : (r_num - 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_num <= '0;
            r_tc  <= 1'b0;
            r_evt <= '0;
        end else begin
            r_num <= w_num_next;
            r_tc  <= w_tc_next;
            r_evt <= w_evt_next;
        end
    end

    assign num     = r_num;
    assign tc      = r_tc;
    assign evt_cnt = r_evt;

endmodule
`default_nettype wire

// File: doc/counter_param.md
# counter_param

Parametrised synchronous up/down counter with configurable width, modulo limit, and wrap or saturate mode. It succeeds the fixed 16-bit free-running counter and adds enable, direction, parallel load, synchronous clear, and a terminal-count pulse with a saturating event counter. It is the standard count/timer primitive for the counter subtree, instantiated wherever a modulo-N or bounded count is needed.

## Interface
- `WIDTH`, default 16: counter width in bits, 2..32.
- `MAX_VAL`, default 2**WIDTH-1: inclusive upper count limit; count range is 0..MAX_VAL.
- `SATURATE`, default 0: 0 = wrap at the limits; 1 = hold at the limits.
- `EVT_W`, default 8: width of the boundary-event counter.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset is synchronous and active-high.
- `clear`  in  1  synchronous clear of `num` to 0.
- `load`  in  1  synchronous parallel load.
- `load_val`  in  WIDTH  load data.
- `en`  in  1  count enable.
- `up_dn`  in  1  1 = count up, 0 = count down.
- `num`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal-count pulse, registered, one cycle per boundary event.
- `evt_cnt`  out  EVT_W  number of boundary events since reset/clear; saturates at all-ones.

## Operation
- Priority each cycle, highest first: `rst`, `clear`, `load`, `en`. Only the highest active action takes effect.
- `rst`: `num`=0, `tc`=0, `evt_cnt`=0.
- `clear`: `num`=0, `tc`=0, `evt_cnt`=0. Behaves the same as `rst` but is a functional input.
- `load`:
  - `num` = `load_val` if `load_val` <= MAX_VAL; otherwise `num` = MAX_VAL (clamp).
  - `tc`=0; `evt_cnt` is unchanged.
- `en`, up direction:
  - `num` < MAX_VAL: `num`+1.
  - `num` == MAX_VAL: boundary event; `num` goes to 0 (SATURATE=0) or holds at MAX_VAL (SATURATE=1).
- `en`, down direction:
  - `num` > 0: `num`-1.
  - `num` == 0: boundary event; `num` goes to MAX_VAL (SATURATE=0) or holds at 0 (SATURATE=1).
- On a boundary event:
  - `tc`=1 on the next cycle.
  - `evt_cnt` increments, but holds once it reaches 2**EVT_W-1.
  - In saturate mode, every enabled cycle spent at the limit is a new event, so `tc` stays high continuously.
- No enabled action: `num` and `evt_cnt` hold, and `tc`=0.
- `up_dn` is sampled each cycle. A direction change takes effect on that same edge and needs no idle cycle.
- Arithmetic is unsigned, modulo MAX_VAL+1. `num` never leaves 0..MAX_VAL.
- Elaboration check: MAX_VAL must be >= 1 and <= 2**WIDTH-1; otherwise elaboration fails.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Latency from an input to its effect on `num`, `tc`, and `evt_cnt` is 1 clock (visible after the next rising edge).
- `tc` is asserted in the same cycle that `num` shows the wrapped or held value.
- Reset values: `num`=0, `tc`=0, `evt_cnt`=0.
- Asserting `rst` mid-count overrides everything on that edge. Counting resumes on the first edge after `rst` deasserts, if `en` is high.
- `load` together with `en` in the same cycle: the load wins and no count step occurs.
- Throughput: one count step per clock.

## Test plan
- Default parameters, `en`=1, `up_dn`=1, starting from reset:
  - `num` reads 0,1,2,…,65535.
  - After the 65536th step, `num`=0 with `tc`=1 for exactly one cycle, and `evt_cnt`=1.
- MAX_VAL=9, counting up for 25 cycles:
  - `num` sequence is 0..9,0..9,0..4.
  - `tc` pulses at steps 10 and 20; `evt_cnt`=2.
- MAX_VAL=9, SATURATE=1, load 7, count up 5 cycles:
  - `num` = 8,9,9,9,9.
  - `tc` stays high for the last 3 cycles; `evt_cnt`=3.
- MAX_VAL=9, `load_val`=15 → `num`=9 (clamped). Then count down 12 cycles (SATURATE=0):
  - `num` = 8..0,9,8,7.
  - One `tc` pulse, in the cycle `num` shows 9.
- Simultaneous inputs:
  - `load`=1 (`load_val`=3) with `en`=1 and `clear`=1 → `num`=0.
  - Next cycle `load`+`en` → `num`=3.
  - Next cycle `en` with `up_dn`=0 → `num`=2.
- Reset mid-operation:
  - At `num`=1234 with `evt_cnt`=5, pulse `rst` for 1 cycle → `num`=0, `evt_cnt`=0, `tc`=0.
  - Counting resumes 0→1 on the following edge.
  - Also drive 300 wraps with EVT_W=8 → `evt_cnt` holds at 255.
